// File: rtl/e_pkg.sv
// Shared types, constants and request-mask helpers for the car sequencer.
// any_above/any_below take zero-extended floor vectors (up to E_MAXF floors).
package e_pkg;

  typedef enum logic [1:0] {
    E_IDLE = 2'd0,
    E_MOVE = 2'd1,
    E_DOOR = 2'd2
  } e_state_t;

  localparam logic E_UP = 1'b1;
  localparam logic E_DN = 1'b0;

  localparam int E_MAXF = 32;

  // Any request strictly above the one-hot floor.
  function automatic logic any_above(
    input logic [E_MAXF-1:0] pend,
    input logic [E_MAXF-1:0] cur
  );
    return |(pend & ~(cur | (cur - 32'd1)));
  endfunction

  // Any request strictly below the one-hot floor.
  function automatic logic any_below(
    input logic [E_MAXF-1:0] pend,
    input logic [E_MAXF-1:0] cur
  );
    return |(pend & (cur - 32'd1));
  endfunction

endpackage

// File: rtl/e_cycle_timer.sv
// Loadable, clearable up-counter with a terminal-count flag.
// Ports: clr_i/ld_i/en_i (priority in that order), ld_val_i, tc_val_i, cnt_o, tc_o.
module e_cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic [W-1:0] tc_val_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (ld_i) cnt_d = ld_val_i;
    else if (en_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == tc_val_i);

endmodule

// File: rtl/e_car_sequencer.sv
// Single elevator car sequencer: latches floor requests, sweeps up/down,
// times floor-to-floor travel and door dwell with one shared timer.
// Ports: clk, rst (async, high), bts[NFLR] button levels,
//   door_hold (only with E_DOOR_HOLD_EN defined: freezes the dwell),
//   cur_flr[NFLR] one-hot floor, dir (1=up), moving, door_open,
//   pending[NFLR] latched requests not yet serviced.
module e_car_sequencer
  import e_pkg::*;
#(
  parameter int NFLR       = 4,
  parameter int TRAVEL_CYC = 8,
  parameter int DOOR_CYC   = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NFLR-1:0] bts,
`ifdef E_DOOR_HOLD_EN
  input  logic            door_hold,
`endif
  output logic [NFLR-1:0] cur_flr,
  output logic            dir,
  output logic            moving,
  output logic            door_open,
  output logic [NFLR-1:0] pending
);

  localparam int TMAX =
    (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TRAVEL_CYC - 1);
  localparam logic [TW-1:0] D_LAST = TW'(DOOR_CYC - 1);

  e_state_t        state_q, state_d;
  logic [NFLR-1:0] flr_q, flr_d;
  logic            dir_q, dir_d;
  logic [NFLR-1:0] pend_q, pend_d;

  logic [NFLR-1:0] req;
  logic [NFLR-1:0] clr;
  logic [NFLR-1:0] nxt_flr;
  logic            at_end;
  logic            hold_w;
  logic            t_clr;
  logic            t_en;
  logic            t_tc;
  logic [TW-1:0]   t_cnt;
  logic [TW-1:0]   t_last;

  logic [E_MAXF-1:0] req_x;
  logic [E_MAXF-1:0] flr_x;
  logic [E_MAXF-1:0] nxt_x;

`ifdef E_DOOR_HOLD_EN
  assign hold_w = door_hold;
`else
  assign hold_w = 1'b0;
`endif

  // Presses on this edge join the latched set before any decision.
  assign req = pend_q | bts;

  // Floor one step toward dir, pinned at the shaft ends.
  assign at_end  = dir_q ? flr_q[NFLR-1] : flr_q[0];
  assign nxt_flr = at_end ? flr_q
                 : (dir_q ? (flr_q << 1) : (flr_q >> 1));

  assign req_x = E_MAXF'(req);
  assign flr_x = E_MAXF'(flr_q);
  assign nxt_x = E_MAXF'(nxt_flr);

  assign t_last = (state_q == E_MOVE) ? T_LAST : D_LAST;

  e_cycle_timer #(
    .W(TW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (t_clr),
    .en_i    (t_en),
    .ld_i    (1'b0),
    .ld_val_i('0),
    .tc_val_i(t_last),
    .cnt_o   (t_cnt),
    .tc_o    (t_tc)
  );

  always_comb begin
    state_d = state_q;
    flr_d   = flr_q;
    dir_d   = dir_q;
    clr     = '0;
    t_clr   = 1'b0;
    t_en    = 1'b0;
    unique case (state_q)
      E_IDLE: begin
        clr = flr_q;
        if (|(req & flr_q)) begin
          state_d = E_DOOR;
        end else if (any_above(req_x, flr_x) &&
                     (dir_q || !any_below(req_x, flr_x))) begin
          dir_d   = E_UP;
          state_d = E_MOVE;
        end else if (any_below(req_x, flr_x)) begin
          dir_d   = E_DN;
          state_d = E_MOVE;
        end
      end
      E_MOVE: begin
        t_en = 1'b1;
        if (t_tc) begin
          flr_d = nxt_flr;
          t_clr = 1'b1;
          if (|(req & nxt_flr)) begin
            clr     = nxt_flr;
            state_d = E_DOOR;
          end else if (dir_q ? !any_above(req_x, nxt_x)
                             : !any_below(req_x, nxt_x)) begin
            state_d = E_IDLE;
          end
        end
      end
      E_DOOR: begin
        clr = flr_q;
        // A press at this floor restarts the dwell.
        if (|(bts & flr_q)) begin
          t_clr = 1'b1;
        end else if (!hold_w) begin
          if (t_tc) state_d = E_IDLE;
          else      t_en    = 1'b1;
        end
      end
      default: state_d = E_IDLE;
    endcase
    if (state_d != state_q) t_clr = 1'b1;
    pend_d = req & ~clr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= E_IDLE;
      flr_q   <= NFLR'(1);
      dir_q   <= E_DN;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      flr_q   <= flr_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
    end
  end

  assign cur_flr   = flr_q;
  assign dir       = dir_q;
  assign moving    = (state_q == E_MOVE);
  assign door_open = (state_q == E_DOOR);
  assign pending   = pend_q;

endmodule

// File: tb/tb_e_car_sequencer.sv
// Scoreboard bench for e_car_sequencer (NFLR=4, TRAVEL_CYC=4, DOOR_CYC=3).
// Output-change events are compared to queued expectations incl. timing.
module tb_e_car_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] bts = '0;
`ifdef E_DOOR_HOLD_EN
  logic       door_hold = 1'b0;
`endif
  logic [3:0] cur_flr;
  logic       dir;
  logic       moving;
  logic       door_open;
  logic [3:0] pending;

  e_car_sequencer #(
    .NFLR(4), .TRAVEL_CYC(4), .DOOR_CYC(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bts      (bts),
`ifdef E_DOOR_HOLD_EN
    .door_hold(door_hold),
`endif
    .cur_flr  (cur_flr),
    .dir      (dir),
    .moving   (moving),
    .door_open(door_open),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  // rf: 0 = gap from previous event, 1 = gap from mark, 2 = untimed
  typedef struct {
    logic [10:0] obs;
    int          rf;
    int          gap;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   mark = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_ev = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic ev(input logic [3:0] f, input logic d, input logic m,
                    input logic o, input logic [3:0] p,
                    input int rf, input int gap);
    exp_t e;
    e.obs = {f, d, m, o, p};
    e.rf  = rf;
    e.gap = gap;
    q.push_back(e);
  endtask

  // Monitor: any change of the observed outputs is an event.
  logic [10:0] prev_obs;
  bit          have_prev = 0;
  int          last_cyc = 0;

  always @(negedge clk) begin
    logic [10:0] obs;
    exp_t        e;
    int          g;
    obs = {cur_flr, dir, moving, door_open, pending};
    if (!have_prev || obs != prev_obs) begin
      n_ev++;
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL ev%0d unexpected obs=%b at cyc %0d",
                 n_ev, obs, cyc);
      end else begin
        e = q.pop_front();
        g = (e.rf == 0) ? (cyc - last_cyc) : (cyc - mark);
        if (obs !== e.obs || (e.rf != 2 && g != e.gap)) begin
          n_err++;
          $display("FAIL ev%0d got obs=%b gap=%0d want obs=%b gap=%0d",
                   n_ev, obs, g, e.obs, e.gap);
        end
      end
      prev_obs  = obs;
      have_prev = 1;
      last_cyc  = cyc;
    end
  end

  task automatic press(input logic [3:0] v);
    @(posedge clk);
    #1;
    bts  = v;
    mark = cyc;
    @(posedge clk);
    #1;
    bts = '0;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s timeout: %0d events outstanding, want 0",
               nm, q.size());
      q.delete();
    end
  endtask

  task automatic wait_at(input string nm, input logic [3:0] f,
                         input logic door);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(cur_flr == f &&
                 (door ? door_open : moving)) && n < 300);
    if (n >= 300) begin
      n_vec++;
      n_err++;
      $display("FAIL %s timeout: cur_flr=%b, want %b", nm, cur_flr, f);
    end
  endtask

  initial begin
    // 1: reset state, then idle for 20 cycles with no activity
    ev(4'b0001, 0, 0, 0, 4'b0000, 2, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    wait_drain("reset");

    // 2: press at current floor -> 3-cycle dwell, nothing latched
    ev(4'b0001, 0, 0, 1, 4'b0000, 1, 1);
    ev(4'b0001, 0, 0, 0, 4'b0000, 0, 3);
    press(4'b0001);
    wait_drain("door0");

    // 2b: second press during dwell restarts it (5 cycles total)
    ev(4'b0001, 0, 0, 1, 4'b0000, 1, 1);
    ev(4'b0001, 0, 0, 0, 4'b0000, 0, 5);
    press(4'b0001);
    press(4'b0001);
    wait_drain("restart");

    // 3: sweep up to floor 3
    ev(4'b0001, 1, 1, 0, 4'b1000, 1, 1);
    ev(4'b0010, 1, 1, 0, 4'b1000, 0, 4);
    ev(4'b0100, 1, 1, 0, 4'b1000, 0, 4);
    ev(4'b1000, 1, 0, 1, 4'b0000, 0, 4);
    press(4'b1000);
    wait_at("up3", 4'b1000, 1'b1);

    // 5: presses 0001 then 0100 while door open at floor 3
    ev(4'b1000, 1, 0, 1, 4'b0001, 0, 2);
    ev(4'b1000, 1, 0, 0, 4'b0101, 0, 1);
    ev(4'b1000, 0, 1, 0, 4'b0101, 0, 1);
    ev(4'b0100, 0, 0, 1, 4'b0001, 0, 4);
    ev(4'b0100, 0, 0, 0, 4'b0001, 0, 3);
    ev(4'b0100, 0, 1, 0, 4'b0001, 0, 1);
    ev(4'b0010, 0, 1, 0, 4'b0001, 0, 4);
    ev(4'b0001, 0, 0, 1, 4'b0000, 0, 4);
    ev(4'b0001, 0, 0, 0, 4'b0000, 0, 3);
    @(posedge clk);
    #1 bts = 4'b0001;
    @(posedge clk);
    #1 bts = 4'b0100;
    @(posedge clk);
    #1 bts = 4'b0000;
    wait_drain("down");

    // 4: 1010 in one pulse: stop at floor 1, continue to floor 3
    ev(4'b0001, 1, 1, 0, 4'b1010, 1, 1);
    ev(4'b0010, 1, 0, 1, 4'b1000, 0, 4);
    ev(4'b0010, 1, 0, 0, 4'b1000, 0, 3);
    ev(4'b0010, 1, 1, 0, 4'b1000, 0, 1);
    ev(4'b0100, 1, 1, 0, 4'b1000, 0, 4);
    ev(4'b1000, 1, 0, 1, 4'b0000, 0, 4);
    ev(4'b1000, 1, 0, 0, 4'b0000, 0, 3);
    press(4'b1010);
    wait_drain("mid");

    // 6: reset mid-travel between floors 2 and 1 takes effect at once
    ev(4'b1000, 0, 1, 0, 4'b0001, 1, 1);
    ev(4'b0100, 0, 1, 0, 4'b0001, 0, 4);
    ev(4'b0001, 0, 0, 0, 4'b0000, 1, 0);
    press(4'b0001);
    wait_at("pass2", 4'b0100, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b1;
    mark = cyc;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    wait_drain("rst");

`ifdef E_DOOR_HOLD_EN
    // hold 10 cycles at dwell start: 10 frozen + 3 counted
    ev(4'b0001, 0, 0, 1, 4'b0000, 1, 1);
    ev(4'b0001, 0, 0, 0, 4'b0000, 0, 13);
    press(4'b0001);
    door_hold = 1'b1;
    repeat (10) @(posedge clk);
    #1 door_hold = 1'b0;
    wait_drain("hold");
`endif

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
